// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester arbiter and sequencer for a single-port 1024x8 synchronous
// memory. One command is in flight at a time. Writes occupy the memory port
// for two cycles. Reads occupy it for three cycles, and the read data is
// returned to the requester that issued the read.
//
// Build option:
//   MEM_ARB_RR_EN - when defined, contention is resolved round-robin using a
//                   last-grant pointer (reset value 1, so requester 0 wins the
//                   first contention). When undefined, requester 0 has fixed
//                   priority and no pointer exists.
//
// Ports:
//   clk, reset                   clock; asynchronous active-high reset
//   reqN_valid/we/addr/wdata     command from requester N (N = 0, 1)
//   reqN_ready                   combinational accept for requester N
//   rspN_valid, rspN_rdata       registered read response to requester N
//   mem_wr_en, mem_rd_en         registered memory strobes (mutually exclusive)
//   mem_addr, mem_wdata          registered memory address / write data
//   mem_rdata                    memory read data
//   busy                         high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [7:0]            req0_wdata,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [7:0]            req1_wdata,
   output logic                  req1_ready,
   output logic                  rsp0_valid,
   output logic [7:0]            rsp0_rdata,
   output logic                  rsp1_valid,
   output logic [7:0]            rsp1_rdata,
   output logic                  mem_wr_en,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_wdata,
   input  logic [7:0]            mem_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   state_t                state_r;
   logic                  id_r;
   logic                  we_r;
   logic                  busy_r;
   logic                  rsp0_valid_r;
   logic                  rsp1_valid_r;
   logic [7:0]            rsp0_rdata_r;
   logic [7:0]            rsp1_rdata_r;
   logic                  mem_wr_en_r;
   logic                  mem_rd_en_r;
   logic [ADDR_WIDTH-1:0] mem_addr_r;
   logic [7:0]            mem_wdata_r;

   logic                  grant0_s;
   logic                  grant1_s;
   logic                  idle_s;
   logic                  ready0_s;
   logic                  ready1_s;
   logic                  xfer_s;
   logic                  sel_s;
   logic                  sel_we_s;
   logic [ADDR_WIDTH-1:0] sel_addr_s;
   logic [7:0]            sel_wdata_s;

`ifdef MEM_ARB_RR_EN
   logic                  last_r;

   // Round-robin grant: on contention, the requester not granted last wins
   always_comb begin
      if (req0_valid && req1_valid) begin
         grant0_s = last_r;
         grant1_s = ~last_r;
      end else begin
         grant0_s = req0_valid;
         grant1_s = req1_valid;
      end
   end

   // Last-grant pointer, advanced only when a command is actually accepted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_r <= 1'b1;
      end else if (xfer_s) begin
         last_r <= sel_s;
      end else begin
         last_r <= last_r;
      end
   end
`else
   // Fixed priority grant: requester 0 always wins contention
   always_comb begin
      grant0_s = req0_valid;
      grant1_s = req1_valid & ~req0_valid;
   end
`endif

   // Accept path and command select; ready is forced low while reset is held
   always_comb begin
      idle_s   = (state_r == ST_IDLE);
      ready0_s = grant0_s & idle_s & ~reset;
      ready1_s = grant1_s & idle_s & ~reset;
      xfer_s   = ready0_s | ready1_s;
      sel_s    = ready1_s;
      if (sel_s) begin
         sel_we_s    = req1_we;
         sel_addr_s  = req1_addr;
         sel_wdata_s = req1_wdata;
      end else begin
         sel_we_s    = req0_we;
         sel_addr_s  = req0_addr;
         sel_wdata_s = req0_wdata;
      end
   end

   // Sequencer FSM with all memory-side and response outputs registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         id_r         <= 1'b0;
         we_r         <= 1'b0;
         busy_r       <= 1'b0;
         rsp0_valid_r <= 1'b0;
         rsp1_valid_r <= 1'b0;
         rsp0_rdata_r <= 8'h00;
         rsp1_rdata_r <= 8'h00;
         mem_wr_en_r  <= 1'b0;
         mem_rd_en_r  <= 1'b0;
         mem_addr_r   <= {ADDR_WIDTH{1'b0}};
         mem_wdata_r  <= 8'h00;
      end else begin
         // Response strobes are single-cycle pulses
         rsp0_valid_r <= 1'b0;
         rsp1_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (xfer_s) begin
                  mem_addr_r  <= sel_addr_s;
                  mem_wdata_r <= sel_wdata_s;
                  mem_wr_en_r <= sel_we_s;
                  mem_rd_en_r <= ~sel_we_s;
                  we_r        <= sel_we_s;
                  id_r        <= sel_s;
                  busy_r      <= 1'b1;
                  state_r     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // The memory samples the strobe on this edge
               mem_wr_en_r <= 1'b0;
               mem_rd_en_r <= 1'b0;
               if (we_r) begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               // Route by the id latched at accept, not by the current grant
               if (id_r) begin
                  rsp1_rdata_r <= mem_rdata;
                  rsp1_valid_r <= 1'b1;
               end else begin
                  rsp0_rdata_r <= mem_rdata;
                  rsp0_valid_r <= 1'b1;
               end
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               mem_wr_en_r <= 1'b0;
               mem_rd_en_r <= 1'b0;
               busy_r      <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign req0_ready = ready0_s;
   assign req1_ready = ready1_s;
   assign rsp0_valid = rsp0_valid_r;
   assign rsp1_valid = rsp1_valid_r;
   assign rsp0_rdata = rsp0_rdata_r;
   assign rsp1_rdata = rsp1_rdata_r;
   assign mem_wr_en  = mem_wr_en_r;
   assign mem_rd_en  = mem_rd_en_r;
   assign mem_addr   = mem_addr_r;
   assign mem_wdata  = mem_wdata_r;
   assign busy       = busy_r;

endmodule
